// File: rtl/captura_operandos_pkg.sv
// Shared definitions for the keypad path and the operand capture block.
//   estado_t    : capture FSM states
//   KEY_*       : key codes with a control meaning (0-9 are digits)
//   BLANK_DIGIT : nibble rendered as an unlit 7-segment digit
//   es_digito() : true for decimal key codes
package captura_operandos_pkg;

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        ENTER_B = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        SHOW    = 3'd4
    } estado_t;

    localparam logic [3:0] KEY_OP      = 4'hA;
    localparam logic [3:0] KEY_EQ      = 4'hE;
    localparam logic [3:0] KEY_CLR     = 4'hC;
    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    function automatic logic es_digito(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/captura_operandos_registro.sv
// registro_digitos: holds one BCD operand of up to three digits.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   shift_i   : shift digit_i in from the right (caller checks free room)
//   clear_i   : zero the operand; with shift_i, load digit_i as sole digit
//   digit_i   : BCD digit to shift in
//   value_o   : 3-digit BCD value, right-aligned, zero-padded
//   count_o   : number of digits entered
//   disp_o    : 4-nibble display word, entered digits right-aligned,
//               BLANK in unused positions
module registro_digitos
    import captura_operandos_pkg::*;
#(
    parameter logic [3:0] BLANK = BLANK_DIGIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        shift_i,
    input  logic        clear_i,
    input  logic [3:0]  digit_i,
    output logic [11:0] value_o,
    output logic [1:0]  count_o,
    output logic [15:0] disp_o
);

    logic [11:0] value_q;
    logic [1:0]  count_q;
    logic [15:0] value_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= 12'h000;
            count_q <= 2'd0;
        end else if (clear_i && shift_i) begin
            value_q <= {8'h00, digit_i};
            count_q <= 2'd1;
        end else if (clear_i) begin
            value_q <= 12'h000;
            count_q <= 2'd0;
        end else if (shift_i) begin
            value_q <= {value_q[7:0], digit_i};
            count_q <= count_q + 2'd1;
        end
    end

    assign value_ext = {4'h0, value_q};

    always_comb begin
        disp_o = {4{BLANK}};
        for (int i = 0; i < 4; i++) begin
            if (i < int'(count_q)) begin
                disp_o[i*4 +: 4] = value_ext[i*4 +: 4];
            end
        end
    end

    assign value_o = value_q;
    assign count_o = count_q;

endmodule

// File: rtl/captura_operandos.sv
// captura_operandos: collects two BCD operands from keypad strokes, starts
// the arithmetic unit on '=', and shows its 4-digit result.
// Ports:
//   clk, rst          : system clock, synchronous active-high reset
//   key_valid/key_code: debounced key strobe and code
//   start             : one-cycle request to the arithmetic unit
//   op_a, op_b        : operands, 3 BCD digits, stable while busy
//   done/result       : completion strobe and 4-digit BCD result
//   display           : 4 nibbles for the 7-segment mux, [3:0] rightmost
//   busy              : high while the arithmetic unit owns the operands
//
// state   | meaning
// ENTER_A | collecting digits of operand A
// ENTER_B | collecting digits of operand B
// START   | one-cycle start request
// WAIT    | waiting for done from the arithmetic unit
// SHOW    | result on display, waiting for a new entry
module captura_operandos
    import captura_operandos_pkg::*;
#(
    parameter int         MAX_DIG = 3,
    parameter logic [3:0] BLANK   = BLANK_DIGIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        start,
    output logic [11:0] op_a,
    output logic [11:0] op_b,
    input  logic        done,
    input  logic [15:0] result,
    output logic [15:0] display,
    output logic        busy
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_DIG);

    estado_t     state_q;
    logic        start_q;
    logic        busy_q;
    logic [15:0] result_q;

    logic [1:0]  count_a, count_b;
    logic [15:0] disp_a, disp_b;

    logic key_dig, key_op, key_eq, key_clr;
    logic entry_state;
    logic shift_a, clear_a, shift_b, clear_b;

    assign key_dig = key_valid && es_digito(key_code);
    assign key_op  = key_valid && (key_code == KEY_OP);
    assign key_eq  = key_valid && (key_code == KEY_EQ);
    assign key_clr = key_valid && (key_code == KEY_CLR);

    // States in which the keypad has any effect at all.
    assign entry_state = (state_q == ENTER_A) || (state_q == ENTER_B) ||
                         (state_q == SHOW);

    always_comb begin
        shift_a = 1'b0;
        clear_a = 1'b0;
        shift_b = 1'b0;
        clear_b = 1'b0;
        if (entry_state && key_clr) begin
            clear_a = 1'b1;
            clear_b = 1'b1;
        end
        case (state_q)
            ENTER_A: begin
                shift_a = key_dig && (count_a < MAX_CNT);
                clear_b = clear_b || key_op;
            end
            ENTER_B: begin
                shift_b = key_dig && (count_b < MAX_CNT);
            end
            SHOW: begin
                // A digit after a result starts a fresh entry with it loaded.
                if (key_dig) begin
                    shift_a = 1'b1;
                    clear_a = 1'b1;
                    clear_b = 1'b1;
                end
            end
            default: ;
        endcase
    end

    registro_digitos #(.BLANK(BLANK)) u_reg_a (
        .clk     (clk),
        .rst     (rst),
        .shift_i (shift_a),
        .clear_i (clear_a),
        .digit_i (key_code),
        .value_o (op_a),
        .count_o (count_a),
        .disp_o  (disp_a)
    );

    registro_digitos #(.BLANK(BLANK)) u_reg_b (
        .clk     (clk),
        .rst     (rst),
        .shift_i (shift_b),
        .clear_i (clear_b),
        .digit_i (key_code),
        .value_o (op_b),
        .count_o (count_b),
        .disp_o  (disp_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ENTER_A;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= {4{BLANK}};
        end else begin
            start_q <= 1'b0;
            case (state_q)
                ENTER_A: begin
                    if (key_op) begin
                        state_q <= ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (key_clr) begin
                        state_q <= ENTER_A;
                    end else if (key_eq) begin
                        state_q <= START;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (done) begin
                        result_q <= result;
                        busy_q   <= 1'b0;
                        state_q  <= SHOW;
                    end
                end
                SHOW: begin
                    if (key_clr || key_dig) begin
                        state_q <= ENTER_A;
                    end
                end
                default: begin
                    state_q <= ENTER_A;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Display words come straight from registers; the operand registers
    // already render their entered digits blank-padded.
    always_comb begin
        display = disp_b;
        case (state_q)
            ENTER_A: display = disp_a;
            SHOW:    display = result_q;
            default: display = disp_b;
        endcase
    end

    assign start = start_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_captura_operandos.sv
module tb_captura_operandos;

    logic        clk;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        start;
    logic [11:0] op_a;
    logic [11:0] op_b;
    logic        done;
    logic [15:0] result;
    logic [15:0] display;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    captura_operandos dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .done      (done),
        .result    (result),
        .display   (display),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  key;
        logic [11:0] a;
        logic [11:0] b;
        logic [15:0] disp;
        logic        busy;
        logic        start;
    } vec_t;

    typedef struct packed {
        logic [11:0] a;
        logic [11:0] b;
    } ops_t;

    vec_t tbl[16];
    ops_t sb_q[$];
    int   exp_starts = 0;
    int   seen_starts = 0;
    logic prev_start = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; the key is sampled by the next posedge and the
    // task returns at the following negedge with outputs settled.
    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic pulse_done(input logic [15:0] r, input logic with_key, input logic [3:0] k);
        done      = 1'b1;
        result    = r;
        key_valid = with_key;
        key_code  = k;
        @(negedge clk);
        done      = 1'b0;
        result    = 16'h0000;
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic push_ops(input logic [11:0] a, input logic [11:0] b);
        ops_t o;
        o.a = a;
        o.b = b;
        sb_q.push_back(o);
        exp_starts++;
    endtask

    // Scoreboard side: each start pulse must match the operands queued when
    // '=' was driven, and must last a single cycle.
    always @(negedge clk) begin
        if (!rst && start) begin
            ops_t o;
            seen_starts++;
            chk("start_width", {15'h0, prev_start}, 16'h0000);
            if (sb_q.size() == 0) begin
                chk("start_unexpected", 16'h0001, 16'h0000);
            end else begin
                o = sb_q.pop_front();
                chk("sb_op_a", {4'h0, op_a}, {4'h0, o.a});
                chk("sb_op_b", {4'h0, op_b}, {4'h0, o.b});
            end
        end
        prev_start = start;
    end

    initial begin
        tbl[0]  = '{4'h1, 12'h001, 12'h000, 16'hFFF1, 1'b0, 1'b0};
        tbl[1]  = '{4'h2, 12'h012, 12'h000, 16'hFF12, 1'b0, 1'b0};
        tbl[2]  = '{4'h3, 12'h123, 12'h000, 16'hF123, 1'b0, 1'b0};
        tbl[3]  = '{4'h4, 12'h123, 12'h000, 16'hF123, 1'b0, 1'b0};
        tbl[4]  = '{4'hE, 12'h123, 12'h000, 16'hF123, 1'b0, 1'b0};
        tbl[5]  = '{4'hC, 12'h000, 12'h000, 16'hFFFF, 1'b0, 1'b0};
        tbl[6]  = '{4'hB, 12'h000, 12'h000, 16'hFFFF, 1'b0, 1'b0};
        tbl[7]  = '{4'hA, 12'h000, 12'h000, 16'hFFFF, 1'b0, 1'b0};
        tbl[8]  = '{4'h4, 12'h000, 12'h004, 16'hFFF4, 1'b0, 1'b0};
        tbl[9]  = '{4'h2, 12'h000, 12'h042, 16'hFF42, 1'b0, 1'b0};
        tbl[10] = '{4'hA, 12'h000, 12'h042, 16'hFF42, 1'b0, 1'b0};
        tbl[11] = '{4'hC, 12'h000, 12'h000, 16'hFFFF, 1'b0, 1'b0};
        tbl[12] = '{4'h5, 12'h005, 12'h000, 16'hFFF5, 1'b0, 1'b0};
        tbl[13] = '{4'hA, 12'h005, 12'h000, 16'hFFFF, 1'b0, 1'b0};
        tbl[14] = '{4'h7, 12'h005, 12'h007, 16'hFFF7, 1'b0, 1'b0};
        tbl[15] = '{4'hE, 12'h005, 12'h007, 16'hFFF7, 1'b1, 1'b1};

        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        done      = 1'b0;
        result    = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("rst_op_a",    {4'h0, op_a}, 16'h0000);
        chk("rst_op_b",    {4'h0, op_b}, 16'h0000);
        chk("rst_display", display, 16'hFFFF);
        chk("rst_start",   {15'h0, start}, 16'h0000);
        chk("rst_busy",    {15'h0, busy}, 16'h0000);

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].start) push_ops(tbl[i].a, tbl[i].b);
            press(tbl[i].key);
            chk($sformatf("v%0d_op_a", i), {4'h0, op_a}, {4'h0, tbl[i].a});
            chk($sformatf("v%0d_op_b", i), {4'h0, op_b}, {4'h0, tbl[i].b});
            chk($sformatf("v%0d_display", i), display, tbl[i].disp);
            chk($sformatf("v%0d_busy", i), {15'h0, busy}, {15'h0, tbl[i].busy});
            chk($sformatf("v%0d_start", i), {15'h0, start}, {15'h0, tbl[i].start});
        end

        // Now in START; the following cycles are WAIT.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wait_start", {15'h0, start}, 16'h0000);
            chk("wait_busy",  {15'h0, busy}, 16'h0001);
            chk("wait_op_a",  {4'h0, op_a}, 16'h0005);
            chk("wait_op_b",  {4'h0, op_b}, 16'h0007);
        end

        pulse_done(16'h0012, 1'b0, 4'h0);
        chk("show_display", display, 16'h0012);
        chk("show_busy",    {15'h0, busy}, 16'h0000);
        press(4'hA);
        chk("show_keyA",    display, 16'h0012);
        press(4'hE);
        chk("show_keyE",    display, 16'h0012);
        chk("show_keyE_st", {15'h0, start}, 16'h0000);
        pulse_done(16'h5555, 1'b0, 4'h0);
        chk("show_done_ign", display, 16'h0012);
        press(4'h9);
        chk("new_op_a",     {4'h0, op_a}, 16'h0009);
        chk("new_op_b",     {4'h0, op_b}, 16'h0000);
        chk("new_display",  display, 16'hFFF9);

        // Key C in WAIT has no effect; done still accepted, coincident key ignored.
        press(4'hA);
        press(4'h2);
        push_ops(12'h009, 12'h002);
        press(4'hE);
        @(negedge clk);
        press(4'hC);
        chk("waitC_busy",    {15'h0, busy}, 16'h0001);
        chk("waitC_op_a",    {4'h0, op_a}, 16'h0009);
        chk("waitC_op_b",    {4'h0, op_b}, 16'h0002);
        chk("waitC_display", display, 16'hFFF2);
        pulse_done(16'h0011, 1'b1, 4'h5);
        chk("waitC_done",    display, 16'h0011);
        chk("waitC_keyign",  {4'h0, op_a}, 16'h0009);
        chk("waitC_busy2",   {15'h0, busy}, 16'h0000);
        press(4'hC);
        chk("showC_display", display, 16'hFFFF);
        chk("showC_op_a",    {4'h0, op_a}, 16'h0000);

        // Reset in WAIT wins; a later done is ignored.
        press(4'h8);
        press(4'hA);
        press(4'h6);
        push_ops(12'h008, 12'h006);
        press(4'hE);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstw_op_a",    {4'h0, op_a}, 16'h0000);
        chk("rstw_op_b",    {4'h0, op_b}, 16'h0000);
        chk("rstw_display", display, 16'hFFFF);
        chk("rstw_busy",    {15'h0, busy}, 16'h0000);
        chk("rstw_start",   {15'h0, start}, 16'h0000);
        pulse_done(16'h1234, 1'b0, 4'h0);
        chk("rstw_done_ign", display, 16'hFFFF);
        chk("rstw_busy2",   {15'h0, busy}, 16'h0000);
        press(4'h3);
        chk("rstw_entry",   display, 16'hFFF3);
        chk("rstw_op_a2",   {4'h0, op_a}, 16'h0003);

        repeat (2) @(negedge clk);
        chk("starts_seen", 16'(seen_starts), 16'(exp_starts));
        chk("sb_empty",    16'(sb_q.size()), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
